// File: rtl/gb_apu_wave_ram.sv
// Wave pattern RAM for the custom wave channel: 16 bytes / 32 nibble samples, CPU and channel ports.
// Define GB_APU_WAVE_DMG_QUIRK_EN for the DMG access window; undefined gives CGB behaviour.
module gb_apu_wave_ram #(
  parameter logic [7:0] RESET_FILL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  input  logic       ch_active,
  input  logic       ch_fetch,
  input  logic [3:0] wave_addr,
  output logic [7:0] wave_data
);

  logic [7:0] mem [0:15];
  logic [3:0] eff_addr;
  logic       ok;

  // While playing, the CPU can only reach the byte the channel is on.
  assign eff_addr  = ch_active ? wave_addr : cpu_addr;
  assign wave_data = mem[wave_addr];

`ifdef GB_APU_WAVE_DMG_QUIRK_EN
  logic [1:0] win;
  logic       ch_active_q;

  assign ok = !ch_active || (win != 2'd0);

  // Access window opens for the two cycles after each channel fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      win         <= 2'd0;
      ch_active_q <= 1'b0;
    end else begin
      ch_active_q <= ch_active;
      if (ch_active_q && !ch_active)
        win <= 2'd0;
      else if (ch_fetch)
        win <= 2'd2;
      else if (win != 2'd0)
        win <= win - 2'd1;
    end
  end
`else
  logic unused_fetch;

  assign unused_fetch = ch_fetch;
  assign ok           = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= RESET_FILL;
      cpu_rdata  <= 8'h00;
      cpu_rvalid <= 1'b0;
    end else begin
      if (cpu_wr && ok)
        mem[eff_addr] <= cpu_wdata;
      cpu_rvalid <= cpu_rd;
      // Read samples the pre-write byte when a write shares the edge.
      if (cpu_rd)
        cpu_rdata <= ok ? mem[eff_addr] : 8'hFF;
    end
  end

endmodule
